// File: rtl/exu_lsu.sv
// Load/store unit: turns EX-stage memory ops into bus requests and load responses into writebacks.
// Latency: request is combinational to the bus; writeback is registered one cycle after the response.
// Backpressure: req_ready_o follows bus_req_ready_i and stalls while OST_DEPTH ops are outstanding (no pop bypass).
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   req_valid_i/req_ready_o, op_i,
//   addr_i, wdata_i, rd_i               EX-stage op in (op_i: [1:0] size, [2] unsigned, [3] store)
//   bus_req_valid_o/bus_req_ready_i,
//   bus_addr_o, bus_we_o, bus_sel_o,
//   bus_wdata_o                         aligned bus request, lane-shifted store data
//   bus_rsp_valid_i/bus_rsp_ready_o,
//   bus_rdata_i                         in-order bus response
//   wb_valid_o, wb_rd_o, wb_data_o      registered load writeback (1-cycle pulse)
//   misaligned_o, stray_rsp_o, busy_o   status
module exu_lsu #(
  parameter int DW        = 32,
  parameter int OST_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [3:0]      op_i,
  input  logic [31:0]     addr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [4:0]      rd_i,
  output logic            bus_req_valid_o,
  input  logic            bus_req_ready_i,
  output logic [31:0]     bus_addr_o,
  output logic            bus_we_o,
  output logic [DW/8-1:0] bus_sel_o,
  output logic [DW-1:0]   bus_wdata_o,
  input  logic            bus_rsp_valid_i,
  output logic            bus_rsp_ready_o,
  input  logic [DW-1:0]   bus_rdata_i,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_o,
  output logic [DW-1:0]   wb_data_o,
  output logic            misaligned_o,
  output logic            stray_rsp_o,
  output logic            busy_o
);

  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);
  localparam int PW = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
  localparam int CW = $clog2(OST_DEPTH + 1);

  // One tracker entry per outstanding bus op: enough to rebuild the load result.
  typedef struct packed {
    logic [3:0]    op;
    logic [OW-1:0] off;
    logic [4:0]    rd;
  } trk_t;

  trk_t          trk_mem [OST_DEPTH];
  trk_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          misaligned;
  logic          full;
  logic          accept;
  logic          pop;
  logic          load_pop;
  logic [1:0]    size;
  logic [OW-1:0] req_off;
  logic [NB-1:0] size_mask;
  logic [DW-1:0] lane_bits;
  logic [DW-1:0] shifted;
  logic [DW-1:0] keep;
  logic          sign_bit;
  logic [DW-1:0] load_val;

  assign size    = op_i[1:0];
  assign req_off = addr_i[OW-1:0];

  // Doubleword ops cannot be issued on a 32-bit bus; treat them like a misalignment.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'b01:   misaligned = addr_i[0];
      2'b10:   misaligned = |addr_i[1:0];
      2'b11:   misaligned = (DW == 32) ? 1'b1 : |addr_i[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Full is taken from the registered count only, so a same-cycle pop never frees a slot.
  assign full            = (count == CW'(OST_DEPTH));
  assign misaligned_o    = req_valid_i & misaligned;
  assign bus_req_valid_o = req_valid_i & ~misaligned & ~full;
  assign req_ready_o     = misaligned | (bus_req_ready_i & ~full);
  assign accept          = bus_req_valid_o & bus_req_ready_i;
  assign pop             = bus_rsp_valid_i & (count != '0);
  assign bus_rsp_ready_o = 1'b1;
  assign busy_o          = (count != '0);

  // Request side: aligned address, lane enables, data shifted into its lanes.
  always_comb begin
    size_mask = '0;
    case (size)
      2'b00:   size_mask = NB'(1);
      2'b01:   size_mask = NB'(3);
      2'b10:   size_mask = NB'(15);
      default: size_mask = '1;
    endcase
  end

  assign bus_sel_o  = size_mask << req_off;
  assign bus_addr_o = {addr_i[31:OW], {OW{1'b0}}};
  assign bus_we_o   = op_i[3];

  always_comb begin
    lane_bits = '0;
    for (int i = 0; i < NB; i++) begin
      lane_bits[8*i +: 8] = {8{bus_sel_o[i]}};
    end
  end

  assign bus_wdata_o = (wdata_i << {req_off, 3'b000}) & lane_bits;

  // Response side: bring the addressed bytes down to bit 0, then extend.
  assign head    = trk_mem[rd_ptr];
  assign shifted = bus_rdata_i >> {head.off, 3'b000};

  always_comb begin
    keep     = '1;
    sign_bit = 1'b0;
    case (head.op[1:0])
      2'b00:   begin keep = DW'(32'h0000_00FF); sign_bit = shifted[7];  end
      2'b01:   begin keep = DW'(32'h0000_FFFF); sign_bit = shifted[15]; end
      2'b10:   begin keep = DW'(32'hFFFF_FFFF); sign_bit = shifted[31]; end
      default: begin keep = '1;                 sign_bit = 1'b0;        end
    endcase
    load_val = (shifted & keep) | ({DW{sign_bit & ~head.op[2]}} & ~keep);
  end

  assign load_pop = pop & ~head.op[3];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OST_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Entry storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (accept) begin
      trk_mem[wr_ptr] <= '{op: op_i, off: req_off, rd: rd_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_o  <= 1'b0;
      wb_rd_o     <= '0;
      wb_data_o   <= '0;
      stray_rsp_o <= 1'b0;
    end else begin
      wb_valid_o  <= load_pop;
      stray_rsp_o <= bus_rsp_valid_i & (count == '0);
      if (load_pop) begin
        wb_rd_o   <= head.rd;
        wb_data_o <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_exu_lsu.sv
module tb_exu_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // DW=32, OST_DEPTH=2 instance
  logic        req_valid_i, req_ready_o;
  logic [3:0]  op_i;
  logic [31:0] addr_i, wdata_i;
  logic [4:0]  rd_i;
  logic        bus_req_valid_o, bus_req_ready_i, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i, wb_data_o;
  logic [3:0]  bus_sel_o;
  logic        bus_rsp_valid_i, bus_rsp_ready_o, wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic        misaligned_o, stray_rsp_o, busy_o;

  exu_lsu #(.DW(32), .OST_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .op_i(op_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rd_i(rd_i),
    .bus_req_valid_o(bus_req_valid_o), .bus_req_ready_i(bus_req_ready_i),
    .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_wdata_o(bus_wdata_o), .bus_rsp_valid_i(bus_rsp_valid_i),
    .bus_rsp_ready_o(bus_rsp_ready_o), .bus_rdata_i(bus_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .misaligned_o(misaligned_o), .stray_rsp_o(stray_rsp_o), .busy_o(busy_o)
  );

  // DW=64, OST_DEPTH=1 instance
  logic        v64, rr64, bv64, brdy64, we64, rv64, rsprdy64, wbv64, mis64, stray64, busy64;
  logic [3:0]  op64;
  logic [31:0] a64, badr64;
  logic [63:0] wd64, bwd64, rdat64, wbd64;
  logic [4:0]  rd64, wbrd64;
  logic [7:0]  sel64;

  exu_lsu #(.DW(64), .OST_DEPTH(1)) u64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(v64), .req_ready_o(rr64), .op_i(op64),
    .addr_i(a64), .wdata_i(wd64), .rd_i(rd64),
    .bus_req_valid_o(bv64), .bus_req_ready_i(brdy64),
    .bus_addr_o(badr64), .bus_we_o(we64), .bus_sel_o(sel64),
    .bus_wdata_o(bwd64), .bus_rsp_valid_i(rv64),
    .bus_rsp_ready_o(rsprdy64), .bus_rdata_i(rdat64),
    .wb_valid_o(wbv64), .wb_rd_o(wbrd64), .wb_data_o(wbd64),
    .misaligned_o(mis64), .stray_rsp_o(stray64), .busy_o(busy64)
  );

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // ---------------- reference model (byte-level arithmetic) ----------------
  function automatic int m_nb(input logic [3:0] op);
    return 1 << op[1:0];
  endfunction

  function automatic int m_off(input int dw, input logic [31:0] a);
    return int'(a[2:0]) % (dw / 8);
  endfunction

  function automatic logic m_mis(input int dw, input logic [3:0] op, input logic [31:0] a);
    return ((int'(a[2:0]) % m_nb(op)) != 0) || (m_nb(op) > dw / 8);
  endfunction

  function automatic logic [7:0] m_sel(input int dw, input logic [3:0] op, input logic [31:0] a);
    return 8'(((1 << m_nb(op)) - 1) << m_off(dw, a));
  endfunction

  function automatic logic [63:0] m_wdata(input int dw, input logic [3:0] op,
                                          input logic [31:0] a, input logic [63:0] wd);
    logic [63:0] v = wd;
    if (m_nb(op) < 8) v = v & ((64'd1 << (8 * m_nb(op))) - 64'd1);
    v = v << (8 * m_off(dw, a));
    if (dw == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  function automatic logic [63:0] m_load(input int dw, input logic [3:0] op,
                                         input int off, input logic [63:0] rdat);
    logic [63:0] v = rdat >> (8 * off);
    logic [63:0] mask;
    int nb = m_nb(op);
    if (nb < 8) begin
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v = v & mask;
      if (!op[2] && v[8*nb-1]) v = v | ~mask;
    end
    if (dw == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  typedef struct { logic [3:0] op; logic [31:0] addr; logic [4:0] rd; } req_t;
  typedef struct { int due; logic [4:0] rd; logic [31:0] data; } wb_t;

  req_t pend[$];
  wb_t  exp_wb[$];
  int   exp_stray[$];
  wb_t  mon_e;

  // ---------------- monitor: writeback / stray scoreboard ----------------
  always @(negedge clk) begin
    if (exp_wb.size() > 0 && exp_wb[0].due == cyc) begin
      mon_e = exp_wb.pop_front();
      chk("wb_valid", wb_valid_o, 1);
      chk("wb_rd", wb_rd_o, mon_e.rd);
      chk("wb_data", wb_data_o, mon_e.data);
    end else begin
      chk("wb_valid_idle", wb_valid_o, 0);
    end
    if (exp_stray.size() > 0 && exp_stray[0] == cyc) begin
      void'(exp_stray.pop_front());
      chk("stray_pulse", stray_rsp_o, 1);
    end else begin
      chk("stray_idle", stray_rsp_o, 0);
    end
  end

  logic        last_rr, last_bv, last_mis, last_we;
  logic [3:0]  last_sel;
  logic [31:0] last_wd;

  // One clock of stimulus on the DW=32 instance; entered and left at negedge+1.
  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] wd, input logic [4:0] rd, input logic brdy,
                      input logic rv, input logic [31:0] rdat);
    int   n;
    logic full, mis;
    req_t r;
    req_valid_i = v; op_i = op; addr_i = a; wdata_i = wd; rd_i = rd;
    bus_req_ready_i = brdy; bus_rsp_valid_i = rv; bus_rdata_i = rdat;
    #1;
    n    = pend.size();
    full = (n == 2);
    mis  = m_mis(32, op, a);
    last_rr = req_ready_o; last_bv = bus_req_valid_o; last_mis = misaligned_o;
    last_sel = bus_sel_o; last_wd = bus_wdata_o; last_we = bus_we_o;
    chk("busy", busy_o, n != 0);
    chk("misaligned", misaligned_o, v & mis);
    chk("bus_req_valid", bus_req_valid_o, v & ~mis & ~full);
    if (v) chk("req_ready", req_ready_o, mis | (brdy & ~full));
    if (rv) begin
      if (n > 0) begin
        r = pend.pop_front();
        if (!r.op[3])
          exp_wb.push_back('{cyc + 1, r.rd,
                             32'(m_load(32, r.op, m_off(32, r.addr), {32'b0, rdat}))});
      end else begin
        exp_stray.push_back(cyc + 1);
      end
    end
    if (v && !mis && !full && brdy) begin
      chk("bus_addr", bus_addr_o, a & 32'hFFFF_FFFC);
      chk("bus_we", bus_we_o, op[3]);
      chk("bus_sel", bus_sel_o, m_sel(32, op, a));
      chk("bus_wdata", bus_wdata_o, m_wdata(32, op, a, {32'b0, wd}));
      pend.push_back('{op, a, rd});
    end
    @(negedge clk); #1;
  endtask

  task automatic idle(input logic rv, input logic [31:0] rdat);
    step(1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, rv, rdat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  sz;
    logic [3:0]  op;
    logic [31:0] a, wd, rdat;
    logic [4:0]  rd;
    logic        v, brdy, rv;

    rst_n = 1'b0;
    req_valid_i = 0; op_i = 0; addr_i = 0; wdata_i = 0; rd_i = 0;
    bus_req_ready_i = 0; bus_rsp_valid_i = 0; bus_rdata_i = 0;
    v64 = 0; op64 = 0; a64 = 0; wd64 = 0; rd64 = 0; brdy64 = 0; rv64 = 0; rdat64 = 0;
    repeat (2) @(negedge clk);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_rd", wb_rd_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_stray", stray_rsp_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_wb64", {wbv64, busy64, stray64}, 0);
    chk("rsp_ready", bus_rsp_ready_o, 1);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;

    // LB / LBU at byte 3
    step(1, 4'b0000, 32'h1003, 0, 5'd5, 1, 0, 0);
    chk("lb_sel", last_sel, 4'b1000);
    idle(1, 32'h80FF_FF7F);
    chk("lb_wb_data", wb_data_o, 32'hFFFF_FF80);
    step(1, 4'b0100, 32'h1003, 0, 5'd6, 1, 0, 0);
    idle(1, 32'h80FF_FF7F);
    chk("lbu_wb_data", wb_data_o, 32'h0000_0080);

    // SH at half 1
    step(1, 4'b1001, 32'h2002, 32'h1234_ABCD, 5'd9, 1, 0, 0);
    chk("sh_sel", last_sel, 4'b1100);
    chk("sh_wdata", last_wd, 32'hABCD_0000);
    chk("sh_we", last_we, 1);
    idle(1, 32'h5555_5555);
    idle(0, 0);

    // misaligned LW
    step(1, 4'b0010, 32'h3001, 0, 5'd3, 1, 0, 0);
    chk("lw_mis", last_mis, 1);
    chk("lw_mis_ready", last_rr, 1);
    chk("lw_mis_bus_valid", last_bv, 0);
    idle(0, 0);

    // tracker full, no same-cycle bypass
    step(1, 4'b0010, 32'h100, 0, 5'd1, 1, 0, 0);
    step(1, 4'b0010, 32'h104, 0, 5'd2, 1, 0, 0);
    step(1, 4'b0010, 32'h108, 0, 5'd3, 1, 0, 0);
    chk("full_stall", last_rr, 0);
    step(1, 4'b0010, 32'h108, 0, 5'd3, 1, 1, 32'h1111_2222);
    chk("no_bypass", last_rr, 0);
    step(1, 4'b0010, 32'h108, 0, 5'd3, 1, 0, 0);
    chk("slot_free", last_rr, 1);
    for (int i = 0; i < 8 && pend.size() > 0; i++) idle(1, $urandom);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      sz = 2'($urandom_range(0, 3));
      op = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz};
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        case (sz)
          2'd1:    a[0]   = 1'b0;
          2'd2:    a[1:0] = 2'b0;
          2'd3:    a[2:0] = 3'b0;
          default: a      = a;
        endcase
      end
      wd   = $urandom;
      rd   = 5'($urandom_range(0, 31));
      v    = ($urandom_range(0, 3) != 0);
      brdy = ($urandom_range(0, 3) != 0);
      rv   = ($urandom_range(0, 2) == 0);
      rdat = $urandom;
      step(v, op, a, wd, rd, brdy, rv, rdat);
    end
    for (int i = 0; i < 8 && pend.size() > 0; i++) idle(1, $urandom);
    idle(0, 0);

    // reset with two loads in flight, then a late response
    step(1, 4'b0010, 32'h200, 0, 5'd7, 1, 0, 0);
    step(1, 4'b0010, 32'h204, 0, 5'd8, 1, 0, 0);
    idle(0, 0);
    rst_n = 1'b0;
    pend.delete();
    repeat (2) @(negedge clk);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_wb", wb_valid_o, 0);
    #1 rst_n = 1'b1;
    idle(1, 32'h8000_0000);
    idle(0, 0);
    chk("post_rst_busy", busy_o, 0);
    idle(0, 0);

    // DW=64 instance
    v64 = 1; op64 = 4'b0010; a64 = 32'h4004; brdy64 = 1; rd64 = 5'd12; #1;
    chk("d64_lw_sel", sel64, 8'hF0);
    chk("d64_lw_valid", bv64, 1);
    chk("d64_lw_addr", badr64, 32'h4000);
    @(negedge clk); #1;
    v64 = 0; rv64 = 1; rdat64 = 64'h8000_0001_0000_0000;
    @(negedge clk); #1;
    rv64 = 0;
    chk("d64_lw_wb_valid", wbv64, 1);
    chk("d64_lw_wb_rd", wbrd64, 12);
    chk("d64_lw_wb_data", wbd64, 64'hFFFF_FFFF_8000_0001);
    v64 = 1; op64 = 4'b0011; a64 = 32'h4004; #1;
    chk("d64_ld_mis", mis64, 1);
    chk("d64_ld_mis_ready", rr64, 1);
    chk("d64_ld_mis_valid", bv64, 0);
    op64 = 4'b0101; a64 = 32'h4006; rd64 = 5'd13; #1;
    chk("d64_lhu_sel", sel64, 8'hC0);
    @(negedge clk); #1;
    chk("d64_wb_one_cycle", wbv64, 0);
    op64 = 4'b0011; a64 = 32'h4008; #1;
    chk("d64_full_stall", rr64, 0);
    rv64 = 1; rdat64 = 64'h8123_4567_89AB_CDEF;
    @(negedge clk); #1;
    rv64 = 0;
    chk("d64_lhu_wb_data", wbd64, m_load(64, 4'b0101, 6, 64'h8123_4567_89AB_CDEF));
    chk("d64_lhu_const", wbd64, 64'h0000_0000_0000_8123);
    chk("d64_ld_sel", sel64, 8'hFF);
    rd64 = 5'd14;
    @(negedge clk); #1;
    v64 = 0; rv64 = 1; rdat64 = 64'hDEAD_BEEF_0123_4567;
    @(negedge clk); #1;
    rv64 = 0;
    chk("d64_ld_wb_data", wbd64, 64'hDEAD_BEEF_0123_4567);
    chk("d64_ld_wb_rd", wbrd64, 14);
    @(negedge clk); #1;

    chk("wb_drain", exp_wb.size(), 0);
    chk("stray_drain", exp_stray.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/exu_lsu.md
EXU_LSU -- requirements
Module: exu_lsu

Interface
REQ-001 Parameter DW, default 32, meaning data bus width in bits; legal values 32 and 64.
REQ-002 Parameter OST_DEPTH, default 2, meaning maximum outstanding bus transactions; power of 2, minimum 1.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  in  1  EX stage presents a memory op.
REQ-006 req_ready_o  out  1  op consumed this cycle.
REQ-007 op_i  in  4  encoding: [1:0] size (00 B, 01 H, 10 W, 11 D); [2] unsigned load; [3] store.
REQ-008 addr_i  in  32  byte address.
REQ-009 wdata_i  in  DW  store data, LSB-aligned.
REQ-010 rd_i  in  5  load destination register.
REQ-011 bus_req_valid_o / bus_req_ready_i  out/in  1  bus request handshake.
REQ-012 bus_addr_o  out  32  addr_i with low log2(DW/8) bits cleared.
REQ-013 bus_we_o  out  1  store request.
REQ-014 bus_sel_o  out  DW/8  byte lane enables.
REQ-015 bus_wdata_o  out  DW  lane-shifted store data.
REQ-016 bus_rsp_valid_i  in  1  bus response valid.
REQ-017 bus_rsp_ready_o  out  1  constant 1.
REQ-018 bus_rdata_i  in  DW  response data.
REQ-019 wb_valid_o / wb_rd_o / wb_data_o  out  1/5/DW  registered load writeback.
REQ-020 misaligned_o  out  1  current op misaligned or illegal, combinational.
REQ-021 stray_rsp_o  out  1  one-cycle pulse: response arrived with no outstanding entry.
REQ-022 busy_o  out  1  outstanding count nonzero.

Function
REQ-023 Misaligned: H with addr[0]!=0; W with addr[1:0]!=0; D with addr[2:0]!=0; D when DW=32 is illegal and flagged the same way.
REQ-024 misaligned_o = req_valid_i & misaligned; the op is consumed (req_ready_o=1) with no bus request, no tracker push, no writeback.
REQ-025 Legal op: bus_req_valid_o = req_valid_i & ~full; req_ready_o = bus_req_ready_i & ~full; accept = bus request handshake.
REQ-026 Full means outstanding count == OST_DEPTH; a pop in the same cycle does not unblock a push (no bypass).
REQ-027 On accept, push tracker FIFO entry {op_i, addr_i low bits, rd_i}; count += 1.
REQ-028 Lane select: B one lane at offset, H two lanes, W four lanes, D all eight; wdata replicated/shifted into selected lanes, unselected lanes 0.
REQ-029 On bus_rsp_valid_i with count>0: pop head; count -= 1; simultaneous push and pop leave count unchanged.
REQ-030 Load pop: extract bytes at stored offset, sign-extend (op[2]=0) or zero-extend (op[2]=1) to DW; W on DW=64 extends from bit 31.
REQ-031 wb_valid_o asserts the cycle after the response, for exactly 1 cycle, with wb_rd_o/wb_data_o held from that pop; store pops produce no writeback.
REQ-032 Responses are in request order; latency from accept to response is unbounded; request and response may occur in the same cycle.
REQ-033 Response with count==0: ignored, stray_rsp_o pulses the following cycle.
REQ-034 Tracker read/write pointers wrap modulo OST_DEPTH.

Reset
REQ-035 During reset: count=0, pointers=0; wb_valid_o, wb_rd_o, wb_data_o, stray_rsp_o, busy_o = 0.
REQ-036 Reset mid-operation discards all outstanding entries; responses arriving after release are treated as stray.

Verification
REQ-037 DW=32: LB addr 0x1003, rdata 0x80FF_FF7F -> sel 4'b1000, wb_data 0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-038 DW=32: SH addr 0x2002, wdata 0x1234_ABCD -> sel 4'b1100, bus_wdata 0xABCD_0000, bus_we 1, no writeback.
REQ-039 LW addr 0x3001 -> misaligned_o=1, req_ready_o=1, bus_req_valid_o=0, count unchanged.
REQ-040 OST_DEPTH=2: three back-to-back loads, no response -> third stalls (req_ready_o=0); one response frees a slot next cycle, not the same cycle.
REQ-041 DW=64: LW addr 0x4004, rdata 0x8000_0001_0000_0000 -> sel 8'hF0, wb_data 0xFFFF_FFFF_8000_0001; LD addr 0x4004 -> misaligned.
REQ-042 Two loads outstanding, rst_n pulsed low, then a response -> no writeback, stray_rsp_o=1 for one cycle, busy_o=0.
